// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and defaults for the MAC round-robin scheduler
package mac_pkg;

  localparam int MAC_DW = 4;
  localparam int MAC_SW = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  // Next round-robin pointer after serving idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mac_rr_arbiter.sv
// rtl/mac_rr_arbiter.sv - combinational round-robin pick: rotate, priority-encode, rotate back
module mac_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PW-1:0]    o_idx,
  output logic             o_any
);

  logic [N_REQ-1:0] w_rot;
  logic [PW-1:0]    w_enc;
  logic             w_found;

  // Bit 0 of w_rot is the requester the pointer currently favours.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] = i_req[(i + int'(i_ptr)) % N_REQ];
    end
  end

  always_comb begin
    w_enc   = '0;
    w_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_enc   = PW'(i);
        w_found = 1'b1;
      end
    end
  end

  assign o_idx = PW'((int'(w_enc) + int'(i_ptr)) % N_REQ);
  assign o_any = w_found;

  always_comb begin
    o_gnt = '0;
    if (w_found) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mac_rr_scheduler.sv
// rtl/mac_rr_scheduler.sv - shares one MAC among N_REQ requesters with round-robin grant and watchdog
module mac_rr_scheduler
  import mac_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DW     = MAC_DW,
  parameter int SW     = MAC_SW,
  parameter int TO_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_vld,
  output logic [SW-1:0]      rsp_sum,
  output logic               rsp_err,
  output logic               busy,
  output logic               mac_go,
  output logic [DW-1:0]      mac_a,
  output logic [DW-1:0]      mac_b,
  input  logic               mac_done,
  input  logic [SW-1:0]      mac_sum
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDW = $clog2(TO_CYC) + 1;

  sched_state_t     r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [N_REQ-1:0] r_owner_oh;
  logic [WDW-1:0]   r_wd;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_rsp_vld;
  logic [SW-1:0]    r_rsp_sum;
  logic             r_rsp_err;
  logic             r_mac_go;
  logic [DW-1:0]    r_mac_a;
  logic [DW-1:0]    r_mac_b;

  logic [N_REQ-1:0] w_win_oh;
  logic [PW-1:0]    w_win_idx;
  logic             w_win_any;
  logic [PW-1:0]    w_ptr_next;
  logic             w_wd_expired;

  mac_rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_win_oh),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  assign w_ptr_next   = PW'(rr_next(int'(r_owner), N_REQ));
  assign w_wd_expired = (r_wd == WDW'(TO_CYC - 1));

  // wd reads 0 in GRANT and counts up through RUN, so the abort lands TO_CYC cycles after gnt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_owner_oh <= '0;
      r_wd       <= '0;
      r_gnt      <= '0;
      r_rsp_vld  <= '0;
      r_rsp_sum  <= '0;
      r_rsp_err  <= 1'b0;
      r_mac_go   <= 1'b0;
      r_mac_a    <= '0;
      r_mac_b    <= '0;
    end else begin
      r_gnt     <= '0;
      r_rsp_vld <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_owner    <= w_win_idx;
            r_owner_oh <= w_win_oh;
            r_mac_a    <= req_a[w_win_idx*DW +: DW];
            r_mac_b    <= req_b[w_win_idx*DW +: DW];
            r_gnt      <= w_win_oh;
            r_mac_go   <= 1'b1;
            r_wd       <= '0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_ptr   <= w_ptr_next;
          r_wd    <= r_wd + WDW'(1);
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_wd <= r_wd + WDW'(1);
          if (mac_done) begin
            r_rsp_sum <= mac_sum;
            r_rsp_err <= 1'b0;
            r_rsp_vld <= r_owner_oh;
            r_mac_go  <= 1'b0;
            r_state   <= ST_RESP;
          end else if (w_wd_expired) begin
            r_rsp_sum <= '0;
            r_rsp_err <= 1'b1;
            r_rsp_vld <= r_owner_oh;
            r_mac_go  <= 1'b0;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mac_go <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign rsp_vld = r_rsp_vld;
  assign rsp_sum = r_rsp_sum;
  assign rsp_err = r_rsp_err;
  assign busy    = (r_state != ST_IDLE);
  assign mac_go  = r_mac_go;
  assign mac_a   = r_mac_a;
  assign mac_b   = r_mac_b;

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb/tb_mac_rr_scheduler.sv - self-checking bench for mac_rr_scheduler
module tb_mac_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int SW = 12;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_vld;
  logic [SW-1:0]   rsp_sum;
  logic            rsp_err;
  logic            busy;
  logic            mac_go;
  logic [DW-1:0]   mac_a;
  logic [DW-1:0]   mac_b;
  logic            mac_done = 1'b0;
  logic [SW-1:0]   mac_sum = '0;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] opa [N];
  logic [DW-1:0] opb [N];
  int model_ptr;

  mac_rr_scheduler #(.N_REQ(N), .DW(DW), .SW(SW), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_vld(rsp_vld), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .busy(busy), .mac_go(mac_go), .mac_a(mac_a), .mac_b(mac_b),
    .mac_done(mac_done), .mac_sum(mac_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = opa[i];
      req_b[i*DW +: DW] = opb[i];
    end
  endtask

  // First asserted requester at or after ptr, wrapping around.
  function automatic int rr_winner(input logic [N-1:0] r, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (r[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0; req = '0; mac_done = 1'b0;
    step(); step();
    rst = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      opa[i] = DW'(i + 1); opb[i] = DW'(i + 9);
    end
    drive_ops();
    rst = 1'b0; req = 4'b1111; mac_done = 1'b1; mac_sum = 12'h5A5;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({gnt, rsp_vld, busy, mac_go, mac_a, mac_b, rsp_sum, rsp_err} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d gnt=%b vld=%b busy=%b go=%b a=%h b=%h sum=%h err=%b (want all 0)",
                 c, gnt, rsp_vld, busy, mac_go, mac_a, mac_b, rsp_sum, rsp_err);
      end
    end
    mac_done = 1'b0;
    rst = 1'b1;
    step();
    total++;
    if (gnt !== 4'b0001 || mac_a !== opa[0] || mac_b !== opb[0]) begin
      bad++;
      $display("FAIL reset_release gnt=%b a=%h b=%h want gnt=0001 a=%h b=%h", gnt, mac_a, mac_b, opa[0], opb[0]);
    end
    req = '0;
  endtask

  task automatic test_single();
    do_reset();
    opa[2] = 4'd3; opb[2] = 4'd5; drive_ops();
    req = 4'b0100;
    step();
    total++;
    if (gnt !== 4'b0100 || mac_go !== 1'b1 || busy !== 1'b1 || mac_a !== 4'd3 || mac_b !== 4'd5) begin
      bad++;
      $display("FAIL single_gnt gnt=%b go=%b busy=%b a=%0d b=%0d want 0100 1 1 3 5", gnt, mac_go, busy, mac_a, mac_b);
    end
    req = '0;
    step();
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL single_gnt_pulse gnt=%b want 0000", gnt);
    end
    repeat (3) step();
    mac_done = 1'b1; mac_sum = 12'd15;
    step();
    mac_done = 1'b0;
    total++;
    if (rsp_vld !== 4'b0100 || rsp_sum !== 12'd15 || rsp_err !== 1'b0 || mac_go !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp vld=%b sum=%0d err=%b go=%b want 0100 15 0 0", rsp_vld, rsp_sum, rsp_err, mac_go);
    end
    step();
    total++;
    if (rsp_vld !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle vld=%b busy=%b want 0000 0", rsp_vld, busy);
    end
  endtask

  task automatic test_back_to_back();
    int cnt [N];
    int win;
    bit got;
    do_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0; opa[i] = DW'($urandom); opb[i] = DW'($urandom);
    end
    drive_ops();
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        step();
        if (gnt != '0) got = 1;
      end
      win = rr_winner(req, model_ptr);
      total++;
      if (!got || gnt !== N'(1 << win) || win != j % N) begin
        bad++;
        $display("FAIL rr_order job=%0d gnt=%b want onehot of %0d", j, gnt, j % N);
      end
      if (got) begin
        for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
      end
      model_ptr = (win + 1) % N;
      step();
      mac_done = 1'b1; mac_sum = SW'(j);
      step();
      mac_done = 1'b0;
      total++;
      if (rsp_vld !== N'(1 << win) || rsp_sum !== SW'(j)) begin
        bad++;
        $display("FAIL rr_rsp job=%0d vld=%b sum=%0d want onehot %0d sum %0d", j, rsp_vld, rsp_sum, win, j);
      end
    end
    req = '0;
    for (int i = 0; i < N; i++) begin
      total++;
      if (cnt[i] != 2) begin
        bad++;
        $display("FAIL rr_fairness req=%0d grants=%0d want 2", i, cnt[i]);
      end
    end
  endtask

  task automatic test_watchdog();
    int n;
    bit seen;
    bit go_ok;
    do_reset();
    opa[1] = 4'd7; opb[1] = 4'd9; drive_ops();
    req = 4'b0010; mac_sum = 12'hABC;
    step();
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL wd_gnt gnt=%b want 0010", gnt);
    end
    req = '0;
    n = 0; seen = 0; go_ok = 1;
    while (!seen && n < 100) begin
      step();
      n++;
      if (rsp_vld != '0) seen = 1;
      else if (mac_go !== 1'b1) go_ok = 0;
    end
    total++;
    if (!seen || n != TO || rsp_vld !== 4'b0010 || rsp_err !== 1'b1 || rsp_sum !== '0) begin
      bad++;
      $display("FAIL wd_abort cycles=%0d vld=%b err=%b sum=%h want %0d 0010 1 0", n, rsp_vld, rsp_err, rsp_sum, TO);
    end
    total++;
    if (!go_ok || mac_go !== 1'b0) begin
      bad++;
      $display("FAIL wd_go held=%0d go_now=%b want 1 0", go_ok, mac_go);
    end
    mac_done = 1'b1;
    step(); step();
    mac_done = 1'b0;
    total++;
    if (rsp_vld !== '0 || busy !== 1'b0 || rsp_err !== 1'b1) begin
      bad++;
      $display("FAIL wd_late_done vld=%b busy=%b err=%b want 0000 0 1", rsp_vld, busy, rsp_err);
    end
  endtask

  task automatic test_reset_mid_job();
    bit leak;
    do_reset();
    opa[2] = 4'd2; opb[2] = 4'd4; opa[0] = 4'd6; opb[0] = 4'd1; drive_ops();
    req = 4'b0100;
    step();
    req = '0;
    step(); step();
    rst = 1'b0; mac_done = 1'b1; mac_sum = 12'd8;
    leak = 0;
    repeat (2) begin
      step();
      if (rsp_vld != '0) leak = 1;
    end
    total++;
    if (leak || mac_go !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_drop leak=%0d go=%b busy=%b want 0 0 0", leak, mac_go, busy);
    end
    mac_done = 1'b0;
    req = 4'b1001;
    rst = 1'b1;
    step();
    total++;
    if (gnt !== 4'b0001 || mac_a !== 4'd6) begin
      bad++;
      $display("FAIL midreset_ptr gnt=%b a=%0d want 0001 6", gnt, mac_a);
    end
    req = '0;
  endtask

  task automatic test_done_on_timeout();
    bit early;
    logic [SW-1:0] s;
    do_reset();
    opa[3] = 4'd11; opb[3] = 4'd13; drive_ops();
    req = 4'b1000;
    step();
    req = '0;
    early = 0;
    repeat (TO - 1) begin
      step();
      if (rsp_vld != '0) early = 1;
    end
    s = SW'($urandom_range(1, 4095));
    mac_done = 1'b1; mac_sum = s;
    step();
    mac_done = 1'b0;
    total++;
    if (early || rsp_vld !== 4'b1000 || rsp_err !== 1'b0 || rsp_sum !== s) begin
      bad++;
      $display("FAIL done_at_timeout early=%0d vld=%b err=%b sum=%h want 0 1000 0 %h", early, rsp_vld, rsp_err, rsp_sum, s);
    end
  endtask

  task automatic test_random();
    int win, k;
    bit got;
    logic [DW-1:0] ea, eb;
    logic [SW-1:0] es;
    logic [N-1:0] r;
    do_reset();
    for (int j = 0; j < 30; j++) begin
      if (req == '0) begin
        r = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) if (r[i]) begin opa[i] = DW'($urandom); opb[i] = DW'($urandom); end
        req = r;
      end
      drive_ops();
      win = rr_winner(req, model_ptr);
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        step();
        if (gnt != '0) got = 1;
      end
      ea = opa[win]; eb = opb[win];
      total++;
      if (!got || gnt !== N'(1 << win) || mac_a !== ea || mac_b !== eb) begin
        bad++;
        $display("FAIL rand_gnt job=%0d gnt=%b a=%h b=%h want onehot %0d a=%h b=%h", j, gnt, mac_a, mac_b, win, ea, eb);
      end
      model_ptr = (win + 1) % N;
      if ($urandom_range(0, 1) == 1) begin
        opa[win] = DW'($urandom); opb[win] = DW'($urandom);
      end else begin
        req[win] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (i != win && !req[i] && $urandom_range(0, 3) == 0) begin
          opa[i] = DW'($urandom); opb[i] = DW'($urandom); req[i] = 1'b1;
        end
      end
      drive_ops();
      k = $urandom_range(1, 5);
      repeat (k) step();
      total++;
      if (mac_go !== 1'b1 || mac_a !== ea || mac_b !== eb || rsp_vld !== '0) begin
        bad++;
        $display("FAIL rand_run job=%0d go=%b a=%h b=%h vld=%b want 1 %h %h 0", j, mac_go, mac_a, mac_b, rsp_vld, ea, eb);
      end
      es = SW'(ea) * SW'(eb);
      mac_sum = es; mac_done = 1'b1;
      step();
      mac_done = 1'b0;
      total++;
      if (rsp_vld !== N'(1 << win) || rsp_sum !== es || rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL rand_rsp job=%0d vld=%b sum=%0d err=%b want onehot %0d sum %0d err 0", j, rsp_vld, rsp_sum, rsp_err, win, es);
      end
    end
    req = '0;
  endtask

  initial begin
    model_ptr = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_job();
    test_done_on_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
